// File: rtl/ushift_pkg.sv
// ============================================================================
//  Module      : ushift_pkg
//  Description : Shared types and helpers for the ushift_reg universal shift
//                register (operating-mode encoding, counter width function).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ushift_pkg;

    // Operating mode carried on the 2-bit mode input
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    // Bits needed to hold a shift count from 0 up to and including width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ushift_reg_dff_bit.sv
// ============================================================================
//  Module      : dff_bit
//  Description : Enable-gated D flip-flop cell with separately registered
//                true and complement outputs; synchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q,
    output logic qb
);

    // Both polarities are stored so qb is a true register output, not an inverter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else if (en) begin
            q  <= d;
            qb <= ~d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ushift_reg.sv
// ============================================================================
//  Module      : ushift_reg
//  Description : Parametrised universal shift register (hold, shift right,
//                shift left, parallel load, optional rotation) with a
//                saturating shift counter and a full-word "done" pulse.
//                Optional feature macro: UREG_PARITY_EN adds a registered
//                even-parity output "par".
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ushift_reg
    import ushift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROTATE = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [1:0]                         mode,
    input  logic                               sin,
    input  logic [WIDTH-1:0]                   pin,
    output logic [WIDTH-1:0]                   q,
    output logic [WIDTH-1:0]                   qb,
    output logic                               sout_r,
    output logic                               sout_l,
    output logic [cnt_width(WIDTH)-1:0]        cnt,
`ifdef UREG_PARITY_EN
    output logic                               done,
    output logic                               par
`else
    output logic                               done
`endif
);

    localparam int                 CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]      CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    mode_t            mode_e;
    logic [WIDTH-1:0] next_q;
    logic             fill_r;
    logic             fill_l;

    assign mode_e = mode_t'(mode);

    // Vacated-bit source: serial input, or the bit leaving the other end when rotating
    always_comb begin
        fill_r = sin;
        fill_l = sin;
        if (ROTATE != 0) begin
            fill_r = q[0];
            fill_l = q[WIDTH-1];
        end
    end

    // Next-state multiplexer feeding the flip-flop bank
    always_comb begin
        next_q = q;
        case (mode_e)
            MODE_SHR:  next_q = {fill_r, q[WIDTH-1:1]};
            MODE_SHL:  next_q = {q[WIDTH-2:0], fill_l};
            MODE_LOAD: next_q = pin;
            default:   next_q = q;
        endcase
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bits
            dff_bit u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     (next_q[i]),
                .q     (q[i]),
                .qb    (qb[i])
            );
        end
    endgenerate

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Shift counter: cleared by load, saturates at WIDTH, pulses done on arrival
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else begin
            case (mode_e)
                MODE_SHR, MODE_SHL: begin
                    if (cnt != CNT_FULL) begin
                        cnt  <= cnt + CW'(1);
                        done <= (cnt == CNT_LAST);
                    end else begin
                        done <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    cnt  <= '0;
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

`ifdef UREG_PARITY_EN
    // Parity tracks the value q is about to take so it lines up with q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (en) begin
            par <= ^next_q;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ushift_reg.sv
// ============================================================================
//  Module      : tb_ushift_reg
//  Description : Self-checking bench for ushift_reg (WIDTH=8), one instance
//                with ROTATE=0 and one with ROTATE=1 sharing stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ushift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin = 1'b0;
    logic [W-1:0] pin = '0;

    logic [W-1:0] q0, qb0, q1, qb1;
    logic         sr0, sl0, sr1, sl1, done0, done1;
    logic [3:0]   cnt0, cnt1;
`ifdef UREG_PARITY_EN
    logic         par0, par1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: register contents as integers, shifts since load
    int m_q0, m_q1, m_cnt;
    bit m_done;

    always #5 clk = ~clk;

    ushift_reg #(.WIDTH(W), .ROTATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .pin(pin),
        .q(q0), .qb(qb0), .sout_r(sr0), .sout_l(sl0), .cnt(cnt0),
`ifdef UREG_PARITY_EN
        .done(done0), .par(par0)
`else
        .done(done0)
`endif
    );

    ushift_reg #(.WIDTH(W), .ROTATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .pin(pin),
        .q(q1), .qb(qb1), .sout_r(sr1), .sout_l(sl1), .cnt(cnt1),
`ifdef UREG_PARITY_EN
        .done(done1), .par(par1)
`else
        .done(done1)
`endif
    );

    // Apply one clock of stimulus and advance the reference model by the rules
    task automatic step(input bit r, input bit e, input int m, input bit s, input int p);
        rst_n = r; en = e; mode = m[1:0]; sin = s; pin = p[W-1:0];
        @(posedge clk);
        if (!r) begin
            m_q0 = 0; m_q1 = 0; m_cnt = 0; m_done = 0;
        end else if (!e) begin
            m_done = 0;
        end else if (m == 3) begin
            m_q0 = p % 256; m_q1 = p % 256; m_cnt = 0; m_done = 0;
        end else if (m == 0) begin
            m_done = 0;
        end else begin
            if (m == 1) begin
                m_q0 = (m_q0 / 2) + 128 * s;
                m_q1 = (m_q1 / 2) + 128 * (m_q1 % 2);
            end else begin
                m_q0 = (m_q0 * 2) % 256 + s;
                m_q1 = (m_q1 * 2) % 256 + (m_q1 / 128);
            end
            if (m_cnt < W) begin
                m_cnt = m_cnt + 1;
                m_done = (m_cnt == W);
            end else begin
                m_done = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 3, 0, 'hA5);
        step(0, 1, 3, 0, 'hA5);
        checks++; if (q0 !== 8'h00)  begin errors++; $display("FAIL reset_q0 got %h want 00", q0); end
        checks++; if (qb0 !== 8'hFF) begin errors++; $display("FAIL reset_qb0 got %h want FF", qb0); end
        checks++; if (q1 !== 8'h00 || qb1 !== 8'hFF) begin errors++; $display("FAIL reset_q1 got %h/%h want 00/FF", q1, qb1); end
        checks++; if (cnt0 !== 4'd0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d/%b want 0/0", cnt0, done0); end
`ifdef UREG_PARITY_EN
        checks++; if (par0 !== 1'b0) begin errors++; $display("FAIL reset_par got %b want 0", par0); end
`endif
    endtask

    task automatic test_shift_right();
        int pulses = 0;
        step(1, 1, 3, 0, 'hA5);
        checks++; if (sr0 !== 1'b1 || sl0 !== 1'b1) begin errors++; $display("FAIL sout_after_load got %b%b want 11", sl0, sr0); end
        step(1, 1, 1, 1, 0);
        checks++; if (q0 !== 8'hD2 || qb0 !== 8'h2D) begin errors++; $display("FAIL shr_first got %h/%h want D2/2D", q0, qb0); end
        checks++; if (q1 !== 8'hD2) begin errors++; $display("FAIL rotr_first got %h want D2", q1); end
        pulses += done0;
        for (int i = 1; i < 8; i++) begin
            step(1, 1, 1, 1, 0);
            pulses += done0;
            checks++; if (done0 !== (i == 7)) begin errors++; $display("FAIL shr_done_%0d got %b want %b", i, done0, i == 7); end
        end
        checks++; if (q0 !== 8'hFF || cnt0 !== 4'd8) begin errors++; $display("FAIL shr_full got %h/%0d want FF/8", q0, cnt0); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL shr_pulses got %0d want 1", pulses); end
        checks++; if (q1 !== 8'hA5) begin errors++; $display("FAIL rotr_full got %h want A5", q1); end
        step(1, 1, 1, 1, 0);
        checks++; if (cnt0 !== 4'd8 || done0 !== 1'b0) begin errors++; $display("FAIL shr_sat got %0d/%b want 8/0", cnt0, done0); end
    endtask

    task automatic test_rotate_left();
        int pulses = 0;
        step(1, 1, 3, 0, 'hA5);
        step(1, 1, 2, 0, 0);
        checks++; if (q1 !== 8'h4B) begin errors++; $display("FAIL rotl_first got %h want 4B", q1); end
        checks++; if (q0 !== 8'h4A) begin errors++; $display("FAIL shl_first got %h want 4A", q0); end
        pulses += done1;
        for (int i = 1; i < 8; i++) begin
            step(1, 1, 2, 0, 0);
            pulses += done1;
        end
        checks++; if (q1 !== 8'hA5 || qb1 !== 8'h5A) begin errors++; $display("FAIL rotl_full got %h/%h want A5/5A", q1, qb1); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL rotl_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_enable_gating();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 3, 1, 'h3C);
            checks++; if (q1 !== 8'hA5 || cnt1 !== 4'd8 || done1 !== 1'b0)
                begin errors++; $display("FAIL en_gate_%0d got %h/%0d/%b want A5/8/0", i, q1, cnt1, done1); end
            checks++; if (q0 !== 8'h00 || qb0 !== 8'hFF) begin errors++; $display("FAIL en_gate_q0_%0d got %h want 00", i, q0); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        step(1, 1, 3, 0, 'h5A);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
        checks++; if (cnt0 !== 4'd3) begin errors++; $display("FAIL mid_cnt got %0d want 3", cnt0); end
        step(0, 1, 1, 1, 0);
        checks++; if (q0 !== 8'h00 || cnt0 !== 4'd0 || done0 !== 1'b0)
            begin errors++; $display("FAIL mid_reset got %h/%0d/%b want 00/0/0", q0, cnt0, done0); end
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 1, 0);
            seen |= done0;
        end
        checks++; if (seen !== 1'b0 || cnt0 !== 4'd5) begin errors++; $display("FAIL mid_nodone got %b/%0d want 0/5", seen, cnt0); end
    endtask

    task automatic test_load_priority();
        step(1, 1, 3, 0, 'h81);
        for (int i = 0; i < 7; i++) step(1, 1, 2, 0, 0);
        step(1, 1, 3, 0, 'h3C);
        checks++; if (cnt0 !== 4'd0 || done0 !== 1'b0 || q0 !== 8'h3C)
            begin errors++; $display("FAIL load_prio got %0d/%b/%h want 0/0/3C", cnt0, done0, q0); end
    endtask

`ifdef UREG_PARITY_EN
    task automatic test_parity();
        step(1, 1, 3, 0, 'h07);
        checks++; if (par0 !== 1'b1) begin errors++; $display("FAIL par_07 got %b want 1", par0); end
        step(1, 1, 3, 0, 'hA5);
        checks++; if (par0 !== 1'b0) begin errors++; $display("FAIL par_A5 got %b want 0", par0); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 255)));
            checks++;
            if (q0 !== m_q0[7:0] || qb0 !== ~m_q0[7:0] || cnt0 !== m_cnt[3:0] || done0 !== m_done)
                begin errors++; $display("FAIL rand0_%0d got %h/%h/%0d/%b want %h/%0d/%b", i, q0, qb0, cnt0, done0, m_q0[7:0], m_cnt, m_done); end
            checks++;
            if (q1 !== m_q1[7:0] || qb1 !== ~m_q1[7:0] || cnt1 !== m_cnt[3:0] || done1 !== m_done)
                begin errors++; $display("FAIL rand1_%0d got %h/%h/%0d/%b want %h/%0d/%b", i, q1, qb1, cnt1, done1, m_q1[7:0], m_cnt, m_done); end
            checks++;
            if (sr0 !== m_q0[0] || sl0 !== m_q0[7] || sr1 !== m_q1[0] || sl1 !== m_q1[7])
                begin errors++; $display("FAIL rand_sout_%0d got %b%b%b%b", i, sl0, sr0, sl1, sr1); end
`ifdef UREG_PARITY_EN
            checks++;
            if (par0 !== ^m_q0[7:0] || par1 !== ^m_q1[7:0])
                begin errors++; $display("FAIL rand_par_%0d got %b/%b want %b/%b", i, par0, par1, ^m_q0[7:0], ^m_q1[7:0]); end
`endif
        end
    endtask

    initial begin
        m_q0 = 0; m_q1 = 0; m_cnt = 0; m_done = 0;
        test_reset();
        test_shift_right();
        test_rotate_left();
        test_enable_gating();
        test_reset_mid();
        test_load_priority();
`ifdef UREG_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
